// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and access-legality helper for the load/store client
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Unsigned widths exist only for loads; stores with BU/HU codes are illegal.
    function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic f;
        f = 1'b0;
        case (f3)
            F3_B:    f = 1'b0;
            F3_BU:   f = is_store;
            F3_H:    f = off[0];
            F3_HU:   f = is_store | off[0];
            F3_W:    f = |off;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/halfword lane extraction for loads and merge for sub-word stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase

        store_data = wdata;
        case (funct3)
            F3_B: begin
                store_data = word;
                store_data[{off, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H:    store_data = off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_storage_client.sv
// rtl/lsu_storage_client.sv - RV32I load/store client driving one storage reader lane and the write port
module lsu_storage_client
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_store,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_rdata,
    output logic                   resp_fault,
    output logic [ADDR_W-1:0]      mem_read_addr,
    output logic                   mem_read_en,
    input  logic                   mem_read_fin,
    input  logic [DATA_W-1:0]      mem_read_data,
    output logic [ADDR_W-1:0]      mem_write_addr,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   mem_write_en,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [1:0]             state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [ADDR_W+1:0]      addr_q;
    logic [2:0]             f3_q;
    logic                   store_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      word_q;
    logic [31:0]            rdata_q;
    logic                   fault_q;

    logic              accept;
    logic              fault_now;
    logic [DATA_W-1:0] align_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_data;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign fault_now = access_fault(req_is_store, req_funct3, req_addr[1:0]);

    // Loads extract straight from the granted read data; stores merge into the captured word.
    assign align_word = (state_q == ST_READ) ? mem_read_data : word_q;

    lsu_lane_align u_lane_align (
        .funct3     (f3_q),
        .off        (addr_q[1:0]),
        .word       (align_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fault_now)
                        state_d = ST_RESP;
                    else if (req_is_store && (req_funct3 == F3_W))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ:  if (mem_read_fin) state_d = store_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            default:  if (resp_ready) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_READ) && !mem_read_fin && (stall_q != {STALL_CNT_W{1'b1}}))
            stall_d = stall_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            stall_q <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (accept) begin
                addr_q  <= req_addr[ADDR_W+1:0];
                f3_q    <= req_funct3;
                store_q <= req_is_store;
                wdata_q <= req_wdata;
                fault_q <= fault_now;
                rdata_q <= '0;
            end
            if ((state_q == ST_READ) && mem_read_fin) begin
                word_q <= mem_read_data;
                if (!store_q)
                    rdata_q <= load_data;
            end
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_rdata     = rdata_q;
    assign resp_fault     = fault_q;
    assign mem_read_en    = (state_q == ST_READ);
    assign mem_read_addr  = addr_q[ADDR_W+1:2];
    assign mem_write_en   = (state_q == ST_WRITE);
    assign mem_write_addr = addr_q[ADDR_W+1:2];
    assign mem_write_data = store_data;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_lsu_storage_client.sv
// tb/tb_lsu_storage_client.sv - directed self-checking bench for lsu_storage_client
module tb_lsu_storage_client;
    import lsu_pkg::*;

    localparam int AW = 28;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_is_store;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_ready, resp_fault;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic          mem_read_en, mem_read_fin, mem_write_en;
    logic [31:0]   mem_read_data, mem_write_data;
    logic [SW-1:0] stall_cycles;

    logic [31:0]   mem [0:15];
    logic          preload;
    int            deny_n = 0;
    int            read_cyc = 0;
    int            rd_cnt = 0, wr_cnt = 0, addr_chg = 0;
    logic          prev_rd_en = 1'b0;
    logic [AW-1:0] prev_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [31:0]   last_wr_data = '0;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    lsu_storage_client #(.ADDR_W(AW), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en),
        .mem_read_fin(mem_read_fin), .mem_read_data(mem_read_data),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .stall_cycles(stall_cycles)
    );

    // Storage model: grant withheld for the first deny_n cycles of each read.
    always @(posedge clk) begin
        read_cyc <= mem_read_en ? read_cyc + 1 : 0;
        if (preload) begin
            mem[4] <= 32'h8123_4567;
            mem[5] <= 32'h0000_0000;
        end else if (mem_write_en) begin
            mem[mem_write_addr[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_fin  = mem_read_en && (read_cyc >= deny_n);
    assign mem_read_data = mem[mem_read_addr[3:0]];

    always @(negedge clk) begin
        if (mem_read_en) begin
            rd_cnt++;
            if (prev_rd_en && (mem_read_addr != prev_rd_addr)) addr_chg++;
        end
        if (mem_write_en) begin
            wr_cnt++;
            last_wr_addr = mem_write_addr;
            last_wr_data = mem_write_data;
        end
        prev_rd_en   = mem_read_en;
        prev_rd_addr = mem_read_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic complete(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, "_resp_drop"}, {31'h0, resp_valid}, 32'h0);
    endtask

    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_fault,
                       input int exp_rd, input int exp_wr);
        int lat, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(st, f3, a, wd, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_fault"}, {31'h0, resp_fault}, {31'h0, exp_fault});
        check({tag, "_rd_cycles"}, rd_cnt - rd0, exp_rd);
        check({tag, "_wr_pulses"}, wr_cnt - wr0, exp_wr);
        complete(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, rd0, wr0;
        rst = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_read_en", {31'h0, mem_read_en}, 32'h0);
        check("rst_write_en", {31'h0, mem_write_en}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_fault", {31'h0, resp_fault}, 32'h0);
        check("rst_stall", {16'h0, stall_cycles}, 32'h0);

        txn("lw",  1'b0, F3_W,  32'h10, 32'h0, 2, 32'h8123_4567, 1'b0, 1, 0);
        check("lw_read_addr", {4'h0, prev_rd_addr}, 32'h4);
        txn("lb",  1'b0, F3_B,  32'h13, 32'h0, 2, 32'hFFFF_FF81, 1'b0, 1, 0);
        txn("lbu", 1'b0, F3_BU, 32'h13, 32'h0, 2, 32'h0000_0081, 1'b0, 1, 0);
        txn("lh",  1'b0, F3_H,  32'h12, 32'h0, 2, 32'hFFFF_8123, 1'b0, 1, 0);
        txn("lhu", 1'b0, F3_HU, 32'h10, 32'h0, 2, 32'h0000_4567, 1'b0, 1, 0);

        txn("sb", 1'b1, F3_B, 32'h11, 32'hAA, 3, 32'h0, 1'b0, 1, 1);
        check("sb_wr_data", last_wr_data, 32'h8123_AA67);
        check("sb_wr_addr", {4'h0, last_wr_addr}, 32'h4);
        txn("lw_after_sb", 1'b0, F3_W, 32'h10, 32'h0, 2, 32'h8123_AA67, 1'b0, 1, 0);

        txn("lw_misaligned", 1'b0, F3_W, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("sh_misaligned", 1'b1, F3_H, 32'h11, 32'h1234, 1, 32'h0, 1'b1, 0, 0);
        txn("store_bad_f3", 1'b1, F3_BU, 32'h10, 32'h55, 1, 32'h0, 1'b1, 0, 0);
        check("stall_before", {16'h0, stall_cycles}, 32'h0);

        deny_n = 5;
        rd0 = rd_cnt;
        issue(1'b0, F3_W, 32'h10, 32'h0, lat);
        deny_n = 0;
        check("stall_lat", lat, 32'd7);
        check("stall_count", {16'h0, stall_cycles}, 32'd5);
        check("stall_addr_stable", addr_chg, 32'h0);
        check("stall_rd_cycles", rd_cnt - rd0, 32'd6);
        check("stall_rdata", resp_rdata, 32'h8123_AA67);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'h0, resp_valid}, 32'h1);
            check("hold_rdata", resp_rdata, 32'h8123_AA67);
            check("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        complete("stall");

        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = F3_H;
        req_addr = 32'h12; req_wdata = 32'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("sh_in_write", {31'h0, mem_write_en}, 32'h1);
        rst = 1'b0;
        #1;
        check("rst_mid_write_en", {31'h0, mem_write_en}, 32'h0);
        check("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_mem4", mem[4], 32'h8123_AA67);
        check("rst_mid_wr_pulses", wr_cnt - wr0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_req_ready", {31'h0, req_ready}, 32'h1);
        check("rel_rdata", resp_rdata, 32'h0);
        check("rel_stall", {16'h0, stall_cycles}, 32'h0);

        txn("sw", 1'b1, F3_W, 32'h14, 32'h1234_5678, 2, 32'h0, 1'b0, 0, 1);
        check("sw_wr_data", last_wr_data, 32'h1234_5678);
        check("sw_wr_addr", {4'h0, last_wr_addr}, 32'h5);
        txn("lw_after_sw", 1'b0, F3_W, 32'h14, 32'h0, 2, 32'h1234_5678, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_storage_client.md
Name: lsu_storage_client

Overview:
- Load/store client that sits directly upstream of the multi-reader/single-writer storage block and drives one of its reader lanes plus its single write port.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the memory stage of the multicycle pipeline.
- Waits for read grant, performs byte/halfword extraction with sign/zero extension, and does read-modify-write for sub-word stores.
- Returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 28, storage word-address width; byte address bits [ADDR_W+1:2] form the word address.
- DATA_W, 32, storage row width; fixed to 32 for RV32I, other values unsupported.
- STALL_CNT_W, 16, width of the saturating grant-wait counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned access or illegal funct3
- mem_read_addr  out  ADDR_W  word address to the storage reader lane
- mem_read_en  out  1  read request to the storage reader lane
- mem_read_fin  in  1  grant from storage, same cycle as data
- mem_read_data  in  DATA_W  storage read data, valid when mem_read_fin=1
- mem_write_addr  out  ADDR_W  word address to the storage write port
- mem_write_data  out  DATA_W  full word to write
- mem_write_en  out  1  write strobe, sampled by storage on rising clk
- stall_cycles  out  STALL_CNT_W  saturating count of READ cycles without grant

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all internal registers and stall_cycles cleared.
  - req_ready=1 once rst=1; resp_valid=0, mem_read_en=0, mem_write_en=0, resp_rdata=0, resp_fault=0.
- States and transitions:
  - IDLE: req_ready=1. A request is accepted when req_valid & req_ready. On accept, register addr, funct3, is_store and wdata, then:
    - fault → RESP
    - load or SB/SH → READ
    - SW → WRITE
  - READ: mem_read_en=1 and mem_read_addr stable until mem_read_fin=1. On the grant cycle, capture mem_read_data. Then load → RESP, SB/SH → WRITE. Each non-granted cycle increments stall_cycles, saturating at all-ones.
  - WRITE: mem_write_en=1 for exactly one cycle.
    - SW writes req_wdata.
    - SB merges wdata[7:0] into byte lane addr[1:0] of the captured word.
    - SH merges wdata[15:0] into halfword lane addr[1] of the captured word.
    - Next state → RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready=1, then → IDLE. No new request is accepted in the same cycle (req_ready is 0 outside IDLE).
- Fault rules:
  - LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]≠0, or funct3 not in the legal load/store set → resp_fault=1, resp_rdata=0.
  - A faulting request never asserts mem_read_en or mem_write_en.
- Load extraction:
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Latency with immediate grant, counting from the accept edge:
  - load: 2 cycles to resp_valid
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - fault: 1 cycle
  - Each lost grant cycle adds one cycle.
- mem_write_en and mem_read_en are decoded from state only, never from inputs combinationally.
- Because mem_write_en is state-decoded, asynchronous reset asserted before the WRITE-cycle rising edge suppresses the write. Reset mid-READ drops mem_read_en immediately; the pending request and its response are discarded.
- The RMW sequence is not atomic against other writers. The storage write port is single-writer, and this block is its only owner.
- Read-after-write: a store's write lands at the edge leaving WRITE, so a following load to the same word observes the new data.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, READ, WRITE, RESP)
  - DATA_W
- One combinational sub-module `lsu_lane_align`, used by both load and store paths:
  - load extract/extend: funct3, addr[1:0], word → rdata
  - store merge: funct3, addr[1:0], old word, wdata → new word

Test Plan:
- LW addr 0x0000_0010, storage word 4 = 0x8123_4567, grant immediate → mem_read_addr=4; resp_rdata=0x8123_4567 two cycles after accept; resp_fault=0.
- LB addr 0x13 on the same word → 0xFFFF_FF81; LBU → 0x0000_0081; LH addr 0x12 → 0xFFFF_8123; LHU addr 0x10 → 0x0000_4567.
- SB addr 0x11, wdata 0xAA, word 4 = 0x8123_4567 → one mem_write_en pulse, data 0x8123_AA67, addr 4; a following LW returns 0x8123_AA67.
- LW addr 0x22 → resp_fault=1, resp_rdata=0, mem_read_en and mem_write_en never asserted, resp 1 cycle after accept.
- LW with mem_read_fin held low 5 cycles → mem_read_addr stable throughout; stall_cycles increments by 5; response arrives 5 cycles late. resp_ready held low 3 cycles → resp_rdata stable and req_ready=0.
- Assert rst=0 during the WRITE state of an SH (before the edge) → no write reaches storage; outputs return to reset values; after release the next SW executes normally.
